sensor_conditioner: RTL
=======================

Name: sensor_conditioner

Overview:
Upstream conditioning stage for the wall-following direction FSM. It takes the four raw contact/proximity sensor lines and debounces each one independently. It outputs clean levels on `sensor[3:0]`, which drive the FSM's `sensor` input directly, plus one-cycle rise/fall pulses and an all-settled flag. Bit order matches the FSM: bit0 gates UP→RIGHT, bit1 RIGHT→DOWN, bit2 DOWN→LEFT, bit3 LEFT→UP.

Parameters:
- N_SENS, 4, number of sensor channels; the FSM requires 4.
- DEB_CYCLES, 16, consecutive differing samples needed to accept a new level. Legal range 1..65535.
- CNT_W, $clog2(DEB_CYCLES+1), counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sensor_raw  input  N_SENS  raw sensor lines
- tick  input  1  sample-enable strobe; tie high to debounce in clk cycles
- sensor  output  N_SENS  debounced level; feeds the direction FSM
- sensor_rise  output  N_SENS  one-clk pulse when sensor[i] goes 0→1
- sensor_fall  output  N_SENS  one-clk pulse when sensor[i] goes 1→0
- stable  output  1  high when no channel has a pending change

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`rst`) is synchronous and active-high.
- Reset values: sensor=0, sensor_rise=0, sensor_fall=0, all counters=0, stable=1. The same applies when rst is asserted mid-count; counting restarts from 0 after release.
- Per channel i, state is the level register deb[i] and the counter cnt[i]. Registers update only on cycles with tick=1.
- Sampled value equals deb[i]: cnt[i] clears to 0 (glitch rejection; no partial credit is kept).
- Sampled value differs and cnt[i] < DEB_CYCLES-1: cnt[i] increments.
- Sampled value differs and cnt[i] == DEB_CYCLES-1:
  - deb[i] toggles and cnt[i] clears.
  - sensor_rise[i] or sensor_fall[i] is registered high for exactly that one clk cycle, the first cycle sensor[i] shows the new level.
- tick=0: deb and cnt hold. Rise/fall pulses still clear after one clk, so a pulse never lasts more than one clk.
- Latency: sensor[i] changes on the clock edge of the DEB_CYCLES-th consecutive differing tick-sample.
  - With tick tied high, that is DEB_CYCLES edges after the raw change is first sampled.
  - DEB_CYCLES=1 gives a flip on the first differing sample.
- stable: combinational, equal to NOR of all cnt[i]!=0. It drops on the first differing sample of any channel and returns when all counters are 0.
- Channels are fully independent. Simultaneous flips on several channels all occur in the same cycle, and rise and fall pulses may coexist across channels.
- No saturation or wrap: cnt never exceeds DEB_CYCLES-1.
- sensor is registered, so it is glitch-free toward the Mealy outputs of the direction FSM.

Optional Feature:
- Macro: SENSOR_SYNC_EN.
- Defined: sensor_raw passes through a 2-flop synchronizer per bit before debounce. The synchronizer flops reset to 0 and are clocked every clk regardless of tick. Latency grows by 2 clk.
- Not defined: sensor_raw is sampled directly; the source must already be synchronous to clk.

Decomposition:
- Shared package sensor_pkg holds:
  - N_SENS = 4.
  - Channel index constants SENS_UP=0, SENS_RIGHT=1, SENS_DOWN=2, SENS_LEFT=3.
  - Direction encoding UP=2'b00, RIGHT=2'b01, DOWN=2'b10, LEFT=2'b11, shared with the direction FSM.
- One natural sub-module: debounce_channel, a single-bit deb/cnt/pulse slice instantiated N_SENS times via generate.
- The synchronizer and the stable reduction stay in the top level.

Test Plan (DEB_CYCLES=4, macro off unless stated):
1. rst for 2 clk, then sensor_raw=0000 for 10 clk, tick=1 → sensor=0000, no rise/fall pulses, stable=1 throughout.
2. sensor_raw[0] 0→1 and held, tick=1 → stable=0 from the first sampled edge; sensor[0]=1 and sensor_rise[0]=1 for exactly one clk at the 4th edge; stable=1 on that same edge.
3. sensor_raw[2]=1 for 3 clk then back to 0, tick=1 → sensor[2] stays 0, no pulse, stable returns to 1 once the sample matches.
4. tick high every 3rd clk, sensor_raw[1] 0→1 held → sensor[1] flips on the 4th tick (~12 clk); no change on non-tick cycles; sensor_rise[1] one clk wide.
5. With sensor=1000 settled, sensor_raw changes to 0010, tick=1 → sensor=0010 on the 4th edge, with sensor_fall[3] and sensor_rise[1] both high in the same single cycle.
6. rst asserted after 2 differing samples → next cycle all outputs at reset values; after release, a held change needs a full 4 samples. With SENSOR_SYNC_EN defined, repeat scenario 2 → flip at edge 6.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor conditioner and the wall-following direction FSM.
package sensor_pkg;

    localparam int unsigned N_SENS = 4;

    localparam int unsigned SENS_UP    = 0;
    localparam int unsigned SENS_RIGHT = 1;
    localparam int unsigned SENS_DOWN  = 2;
    localparam int unsigned SENS_LEFT  = 3;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_e;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: accepts a new level after DEB_CYCLES consecutive differing
// tick-samples and emits a one-clk rise or fall pulse on acceptance.
module debounce_channel #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_sample,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             w_differ;
    logic             w_last;

    assign w_differ = i_sample ^ r_deb;
    assign w_last   = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_deb  <= 1'b0;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            // Pulses are cleared every clk, independent of tick.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_tick) begin
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (w_last) begin
                    r_deb  <= i_sample;
                    r_cnt  <= '0;
                    r_rise <= i_sample;
                    r_fall <= ~i_sample;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_level = r_deb;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_busy  = |r_cnt;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the raw sensor lines feeding the direction FSM.
// Define SENSOR_SYNC_EN to insert a 2-flop synchronizer per bit ahead of debounce.
module sensor_conditioner #(
    parameter int unsigned N_SENS     = sensor_pkg::N_SENS,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SENS-1:0] sensor_raw,
    input  logic              tick,
    output logic [N_SENS-1:0] sensor,
    output logic [N_SENS-1:0] sensor_rise,
    output logic [N_SENS-1:0] sensor_fall,
    output logic              stable
);

    logic [N_SENS-1:0] w_sample;
    logic [N_SENS-1:0] w_busy;

`ifdef SENSOR_SYNC_EN
    logic [N_SENS-1:0] r_sync1;
    logic [N_SENS-1:0] r_sync2;

    // Free-running on clk so the synchronizer settles even while tick is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sensor_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = sensor_raw;
`endif

    for (genvar g = 0; g < N_SENS; g++) begin : g_chan
        debounce_channel #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_chan (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_tick  (tick),
            .i_sample(w_sample[g]),
            .o_level (sensor[g]),
            .o_rise  (sensor_rise[g]),
            .o_fall  (sensor_fall[g]),
            .o_busy  (w_busy[g])
        );
    end

    assign stable = ~|w_busy;

endmodule
